stream_light_btn_ctrl: RTL

Input-side command controller for the stream-light LED block. Takes three raw, bouncy push-button inputs and produces the clean Run/Stop/Reverse level commands the LED sequencer consumes. Per button: 2-FF synchroniser, counter debouncer and rising-edge detector, feeding a small run/stop/direction state machine. Sits between board buttons and the LED sequencer inside the top level.

---
 rtl/stream_light_btn_ctrl_if.sv | 26 ++
 rtl/stream_light_btn_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/stream_light_btn_ctrl_if.sv
// Button/command bundle between the board push buttons and the stream-light
// command controller.
//   btn_run, btn_stop, btn_reverse : raw active-high buttons, async to CLK
//   Run, Stop                      : state levels (never both 1)
//   Reverse                        : direction level
//   state                          : 00 IDLE, 01 RUNNING, 10 STOPPED
// master = board side (drives buttons), slave = controller side.
interface stream_light_btn_ctrl_if;
  logic       btn_run;
  logic       btn_stop;
  logic       btn_reverse;
  logic       Run;
  logic       Stop;
  logic       Reverse;
  logic [1:0] state;

  modport master (
    output btn_run, btn_stop, btn_reverse,
    input  Run, Stop, Reverse, state
  );

  modport slave (
    input  btn_run, btn_stop, btn_reverse,
    output Run, Stop, Reverse, state
  );
endinterface

// File: rtl/stream_light_btn_ctrl.sv
// Stream-light command controller: turns three raw, bouncy push buttons into
// clean Run/Stop/Reverse levels for the LED sequencer.
// Per button: 2-FF synchroniser -> counter debouncer -> rising-edge pulse.
// The pulses drive a run/stop/direction state machine.
// Ports:
//   CLK   : system clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : button inputs and command outputs (slave modport)
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | after reset, no run accepted yet; reverse ignored
// ST_RUNNING | sequencer running; Run = 1
// ST_STOPPED | sequencer halted;  Stop = 1
module stream_light_btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                   CLK,
  input  logic                   Reset,
  stream_light_btn_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_STOPPED = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // bit 0 = run, bit 1 = stop, bit 2 = reverse
  logic [2:0] btn_raw;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] stable_q;
  logic [2:0] stable_dly_q;
  logic [2:0] press;

  assign btn_raw = {bus.btn_reverse, bus.btn_stop, bus.btn_run};

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_d;

    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q[g];
      if (sync2_q[g] != stable_q[g]) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = sync2_q[g];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
        cnt_q           <= '0;
        stable_q[g]     <= 1'b0;
        stable_dly_q[g] <= 1'b0;
      end else begin
        cnt_q           <= cnt_d;
        stable_q[g]     <= stable_d;
        stable_dly_q[g] <= stable_q[g];
      end
    end
  end

  assign press = stable_q & ~stable_dly_q;

  logic   press_run;
  logic   press_stop;
  logic   press_rev;
  state_t state_q;
  state_t state_d;
  logic   reverse_q;
  logic   reverse_d;
  logic   run_q;
  logic   stop_q;

  assign press_run  = press[0];
  assign press_stop = press[1];
  assign press_rev  = press[2];

  always_comb begin
    state_d   = state_q;
    reverse_d = reverse_q;
    case (state_q)
      ST_IDLE: begin
        if (press_run && !press_stop) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (press_stop) state_d = ST_STOPPED;
        if (press_rev)  reverse_d = ~reverse_q;
      end
      ST_STOPPED: begin
        if (press_run && !press_stop) state_d = ST_RUNNING;
        if (press_rev)  reverse_d = ~reverse_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run/Stop are registered from the next state so each output is a single
  // flop and cannot glitch while the two state bits change.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      reverse_q <= 1'b0;
      run_q     <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      reverse_q <= reverse_d;
      run_q     <= (state_d == ST_RUNNING);
      stop_q    <= (state_d == ST_STOPPED);
    end
  end

  assign bus.Run     = run_q;
  assign bus.Stop    = stop_q;
  assign bus.Reverse = reverse_q;
  assign bus.state   = state_q;

endmodule
